// File: rtl/middle_ram_scanner.sv
// ---------------------------------------------------------------------------
// middle_ram_scanner
//
// Read-side master for the middle image RAM. A start pulse makes it walk the
// whole frame in raster order, presenting read coordinates to the RAM
// controller. Read data comes back a fixed RD_LATENCY cycles later. It is
// collected in a small output FIFO and handed downstream as a valid/ready
// stream that carries the coordinates and the end-of-line/end-of-frame flags.
//
// Ports:
//   clock      system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   iStart     frame start request, sampled only while idle
//   oBusy      high while a frame is being scanned or drained
//   oDone      one-cycle pulse after the last pixel was accepted downstream
//   oRdcol     read column to the RAM controller
//   oRdrow     read row to the RAM controller
//   iRddata    RAM read data, RD_LATENCY cycles after the coordinate
//   oValid     output pixel valid (FIFO not empty)
//   iReady     downstream ready
//   oData      pixel value
//   oCol       pixel column
//   oRow       pixel row
//   oEol       pixel is the last one of its line
//   oLast      pixel is the last one of the frame
// ---------------------------------------------------------------------------
module middle_ram_scanner #(
    parameter int WIDTH_BITS      = 8,
    parameter int HEIGHT_BITS     = 8,
    parameter int RD_LATENCY      = 2,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [WIDTH_BITS-1:0]  oRdcol,
    output logic [HEIGHT_BITS-1:0] oRdrow,
    input  logic [7:0]             iRddata,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [7:0]             oData,
    output logic [WIDTH_BITS-1:0]  oCol,
    output logic [HEIGHT_BITS-1:0] oRow,
    output logic                   oEol,
    output logic                   oLast
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 1;
    localparam int EW    = 8 + WIDTH_BITS + HEIGHT_BITS + 2;

    localparam logic [WIDTH_BITS-1:0]  COL_MAX = '1;
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX = '1;
    localparam logic [CW:0]            DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH_BITS-1:0]   col_q, col_d;
    logic [HEIGHT_BITS-1:0]  row_q, row_d;
    logic                    done_q, done_d;

    // In-flight pipe: one stage per cycle of RAM latency
    logic [RD_LATENCY-1:0]                  pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY-1:0][WIDTH_BITS-1:0]  pipe_col_q, pipe_col_d;
    logic [RD_LATENCY-1:0][HEIGHT_BITS-1:0] pipe_row_q, pipe_row_d;
    logic [CW-1:0]                          inflight;

    // Output FIFO
    logic [EW-1:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                fifo_count_q, fifo_count_d;
    logic                         fifo_wr;
    logic                         fifo_rd;
    logic [EW-1:0]                wr_entry;
    logic [EW-1:0]                head;

    logic                         head_last;
    logic                         head_eol;
    logic [HEIGHT_BITS-1:0]       head_row;
    logic [WIDTH_BITS-1:0]        head_col;
    logic [7:0]                   head_data;

    logic [CW:0]                  credit_sum;
    logic                         issue;

    // -----------------------------------------------------------------------
    // Credit-based issue: everything already requested (in flight or
    // buffered) must still fit in the FIFO, so it can never overflow even
    // when downstream stalls indefinitely.
    // -----------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
    end

    assign credit_sum = {1'b0, fifo_count_q} + {1'b0, inflight};
    assign issue      = (state_q == ST_SCAN) && (credit_sum < DEPTH_C);

    // -----------------------------------------------------------------------
    // FSM and read coordinate counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_SCAN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_SCAN: begin
                if (issue) begin
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == ROW_MAX) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_rd && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // In-flight pipe shift; the last stage lines up with iRddata
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_vld_d    = '0;
        pipe_col_d    = '0;
        pipe_row_d    = '0;
        pipe_vld_d[0] = issue;
        pipe_col_d[0] = col_q;
        pipe_row_d[0] = row_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_col_d[i] = pipe_col_q[i-1];
            pipe_row_d[i] = pipe_row_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------
    assign fifo_wr  = pipe_vld_q[RD_LATENCY-1];
    assign fifo_rd  = oValid && iReady;
    assign wr_entry = {
        (pipe_col_q[RD_LATENCY-1] == COL_MAX) && (pipe_row_q[RD_LATENCY-1] == ROW_MAX),
        (pipe_col_q[RD_LATENCY-1] == COL_MAX),
        pipe_row_q[RD_LATENCY-1],
        pipe_col_q[RD_LATENCY-1],
        iRddata
    };

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Storage needs no reset: the count/pointers define what is valid
    always_ff @(posedge clock) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= wr_entry;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            done_q       <= 1'b0;
            pipe_vld_q   <= '0;
            pipe_col_q   <= '0;
            pipe_row_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            done_q       <= done_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_col_q   <= pipe_col_d;
            pipe_row_q   <= pipe_row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs; payload is forced to zero while empty so that reset and idle
    // present all-zero outputs regardless of stale FIFO contents.
    // -----------------------------------------------------------------------
    assign head = fifo_mem[rd_ptr_q];
    assign {head_last, head_eol, head_row, head_col, head_data} = head;

    assign oValid = (fifo_count_q != '0);
    assign oData  = oValid ? head_data : '0;
    assign oCol   = oValid ? head_col  : '0;
    assign oRow   = oValid ? head_row  : '0;
    assign oEol   = oValid && head_eol;
    assign oLast  = oValid && head_last;

    assign oBusy  = (state_q != ST_IDLE);
    assign oDone  = done_q;
    assign oRdcol = col_q;
    assign oRdrow = row_q;

endmodule

// File: tb/tb_middle_ram_scanner.sv
// ---------------------------------------------------------------------------
// Bench for middle_ram_scanner on a 4x4 frame, RAM latency 2, FIFO depth 4.
// The RAM returns row*16+col. A behavioural model (queue of expected beats
// plus an active/done flag) is checked against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_middle_ram_scanner;

    localparam int W    = 2;
    localparam int H    = 2;
    localparam int L    = 2;
    localparam int FB   = 2;
    localparam int NCOL = 1 << W;
    localparam int NROW = 1 << H;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b1;
    logic         iStart  = 1'b0;
    logic         iReady  = 1'b1;
    logic         oBusy, oDone, oValid, oEol, oLast;
    logic [W-1:0] oRdcol, oCol;
    logic [H-1:0] oRdrow, oRow;
    logic [7:0]   iRddata, oData;

    always #5 clock = ~clock;

    middle_ram_scanner #(
        .WIDTH_BITS      (W),
        .HEIGHT_BITS     (H),
        .RD_LATENCY      (L),
        .FIFO_DEPTH_BITS (FB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .iStart  (iStart),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oRdcol  (oRdcol),
        .oRdrow  (oRdrow),
        .iRddata (iRddata),
        .oValid  (oValid),
        .iReady  (iReady),
        .oData   (oData),
        .oCol    (oCol),
        .oRow    (oRow),
        .oEol    (oEol),
        .oLast   (oLast)
    );

    // RAM: coordinate presented in cycle t shows up as data in cycle t+L
    logic [W+H-1:0] ram_pipe [L];
    always @(posedge clock) begin
        ram_pipe[0] <= {oRdrow, oRdcol};
        for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    always_comb begin
        iRddata = 8'(ram_pipe[L-1][W+H-1:W]) * 8'd16 + 8'(ram_pipe[L-1][W-1:0]);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- model and counters ----------------
    typedef struct {
        int data;
        int col;
        int row;
        int eol;
        int last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_active;
    bit    m_done;
    bit    m_start_ok;
    int    m_start_cyc;

    int checks = 0;
    int errors = 0;
    int xfers = 0, eol_cnt = 0, last_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int issues = 0, done_rel = -1;
    bit credit_en = 0;
    logic [W+H-1:0] prev_coord = '0;

    int b_xfers, b_eol, b_last, b_done, b_busy;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) begin
                b.data = r * 16 + c;
                b.col  = c;
                b.row  = r;
                b.eol  = (c == NCOL - 1) ? 1 : 0;
                b.last = (c == NCOL - 1 && r == NROW - 1) ? 1 : 0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Compare process: runs on every falling edge, away from the active edge
    task automatic monitor();
        beat_t b;
        bit    was_active;
        bit    last_popped;
        int    rel;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_valid", int'(oValid), 0);
                check("rst_busy",  int'(oBusy),  0);
                check("rst_done",  int'(oDone),  0);
                check("rst_rdcol", int'(oRdcol), 0);
                check("rst_rdrow", int'(oRdrow), 0);
                exp_q.delete();
                m_active   = 0;
                m_done     = 0;
                m_start_ok = 0;
                prev_coord = '0;
                issues     = xfers;
            end else begin
                check("busy", int'(oBusy), int'(m_active));
                check("done", int'(oDone), int'(m_done));
                if (oDone) begin
                    done_cnt++;
                    done_rel = cyc - m_start_cyc;
                end
                if (oBusy) busy_cnt++;
                if (m_start_ok) begin
                    rel = cyc - m_start_cyc;
                    if (rel >= 1 && rel <= L + 1) check("latency_quiet", int'(oValid), 0);
                    if (rel == L + 2) check("latency_first", int'(oValid), 1);
                end
                if ({oRdrow, oRdcol} != prev_coord) issues++;
                prev_coord = {oRdrow, oRdcol};
                if (credit_en) check("outstanding_le_4", int'((issues - xfers) <= (1 << FB)), 1);

                last_popped = 0;
                if (oValid) begin
                    check("beat_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        b = exp_q[0];
                        check("data", int'(oData), b.data);
                        check("col",  int'(oCol),  b.col);
                        check("row",  int'(oRow),  b.row);
                        check("eol",  int'(oEol),  b.eol);
                        check("last", int'(oLast), b.last);
                        if (iReady) begin
                            void'(exp_q.pop_front());
                            xfers++;
                            if (oEol)  eol_cnt++;
                            if (oLast) last_cnt++;
                            if (b.last != 0) last_popped = 1;
                        end
                    end
                end

                // state for the next cycle
                was_active = m_active;
                if (last_popped) m_active = 0;
                m_done = last_popped;
                if (!was_active && iStart) begin
                    m_active    = 1;
                    m_start_cyc = cyc;
                    m_start_ok  = 1;
                    push_frame();
                end
            end
        end
    endtask

    task automatic snap();
        b_xfers = xfers;
        b_eol   = eol_cnt;
        b_last  = last_cnt;
        b_done  = done_cnt;
        b_busy  = busy_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one (or two back-to-back) frames; stops at ndone pulses, or
    // early after abort_at transfers when abort_at > 0.
    task automatic run_frame(input int ndone, input bit rnd, input bit stall,
                             input int p1, input int p2, input bit b2b,
                             input int abort_at);
        int first_v;
        bit b2b_used;
        first_v  = -1;
        b2b_used = 0;
        @(posedge clock); #1;
        iStart = 1'b1;
        iReady = stall ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        for (int k = 1; k < 600; k++) begin
            @(posedge clock); #1;
            if (done_cnt - b_done >= ndone) break;
            if (abort_at > 0 && xfers - b_xfers >= abort_at) break;
            if (first_v < 0 && oValid) first_v = k;
            iStart = (k == p1) || (k == p2) || (b2b && oDone && !b2b_used);
            if (b2b && oDone) b2b_used = 1;
            if (stall) begin
                iReady = !(first_v < 0 || k < first_v + 10);
                if (first_v >= 0 && k == first_v + 9) begin
                    check("stall_valid", int'(oValid), 1);
                    check("stall_data",  int'(oData),  0);
                end
            end else if (rnd) begin
                iReady = 1'($urandom_range(0, 1));
            end else begin
                iReady = 1'b1;
            end
        end
        iStart = 1'b0;
        iReady = 1'b1;
        if (abort_at == 0) check("frame_done_seen", done_cnt - b_done, ndone);
    endtask

    int seed_val;

    initial begin
        fork
            monitor();
        join_none
        seed_val = $urandom(32'd1234);

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);

        // full rate
        snap();
        run_frame(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        check("t1_xfers", xfers - b_xfers, 16);
        check("t1_eol",   eol_cnt - b_eol, 4);
        check("t1_last",  last_cnt - b_last, 1);
        check("t1_done",  done_cnt - b_done, 1);
        check("t1_done_cycle", done_rel, 20);
        check("t1_busy_cycles", busy_cnt - b_busy, 19);

        // stall
        snap();
        credit_en = 1;
        run_frame(1, 0, 1, 0, 0, 0, 0);
        idle(5);
        check("t2_xfers", xfers - b_xfers, 16);
        check("t2_done",  done_cnt - b_done, 1);

        // random ready
        for (int f = 0; f < 3; f++) begin
            snap();
            run_frame(1, 1, 0, 0, 0, 0, 0);
            idle(5);
            check("t3_xfers", xfers - b_xfers, 16);
            check("t3_eol",   eol_cnt - b_eol, 4);
            check("t3_last",  last_cnt - b_last, 1);
            check("t3_done",  done_cnt - b_done, 1);
        end
        credit_en = 0;

        // iStart during SCAN and DRAIN is ignored
        snap();
        run_frame(1, 0, 0, 6, 18, 0, 0);
        idle(5);
        check("t4_xfers", xfers - b_xfers, 16);
        check("t4_done",  done_cnt - b_done, 1);
        check("t4_done_cycle", done_rel, 20);

        // reset mid-frame
        snap();
        run_frame(1, 0, 0, 0, 0, 0, 5);
        reset_n = 1'b0;
        #1;
        check("abort_valid", int'(oValid), 0);
        check("abort_busy",  int'(oBusy),  0);
        check("abort_done",  int'(oDone),  0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(3);
        check("abort_no_resume", int'(oBusy), 0);
        snap();
        run_frame(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        check("t5_xfers", xfers - b_xfers, 16);
        check("t5_done",  done_cnt - b_done, 1);

        // back-to-back frames
        snap();
        run_frame(2, 0, 0, 0, 0, 1, 0);
        idle(5);
        check("t6_xfers", xfers - b_xfers, 32);
        check("t6_last",  last_cnt - b_last, 2);
        check("t6_done",  done_cnt - b_done, 2);
        check("t6_done_cycle", done_rel, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
